cordic_rx_scheduler: RTL
========================

// Module: cordic_rx_scheduler
// PURPOSE
//  Time-multiplexes one shared, fully pipelined, phase-input CORDIC mixer across NRX receivers.
//  Each ADC sample is issued NRX times, once per receiver, back-to-back.
//  Each issue carries that receiver's NCO phase. Each receiver's phase accumulator advances by its own frequency word.
//  Results are tagged with the receiver index so the downstream per-receiver CIC chains can demultiplex them.
//  Sits between the ADC capture register and the CORDIC. Host frequency writes arrive from the control-bus decoder.
// PARAMETERS
//  NRX        4   number of receivers sharing the CORDIC (2..8)
//  WIDX       2   receiver index width, >= clog2(NRX)
//  IN_WIDTH   16  ADC sample width
//  WF         32  frequency / phase word width (-Pi..Pi per sample; phase 0..2Pi)
//  WO         16  CORDIC output width
//  CORDIC_LAT 20  CORDIC latency, from cordic_issue-high cycle to result-valid cycle
// PORTS
//  clock          in   1         system clock, all logic on rising edge
//  rst_n          in   1         asynchronous reset, active low
//  adc_valid      in   1         one-cycle strobe: adc_I/adc_Q hold a new sample
//  adc_I, adc_Q   in   IN_WIDTH  signed sample
//  freq_wr_en     in   1         host frequency write strobe
//  freq_wr_idx    in   WIDX      target receiver
//  freq_wr_data   in   WF        signed frequency word
//  freq_wr_ack    out  1         one-cycle pulse, cycle after an accepted write
//  overrun_clr    in   1         clears overrun
//  cordic_issue   out  1         CORDIC input valid
//  cordic_I/Q     out  IN_WIDTH  latched sample presented to CORDIC
//  cordic_phase   out  WF        phase for this issue
//  cordic_res_I/Q in   WO        CORDIC result
//  out_valid      out  1         tagged result valid
//  out_idx        out  WIDX      receiver owning the result
//  out_I, out_Q   out  WO        registered result
//  busy           out  1         high while in ISSUE
//  overrun        out  1         sticky: sample dropped
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE. All phase, active-freq and shadow-freq registers are 0. Tag pipe is cleared.
//  FSM states:
//   IDLE -> ISSUE on adc_valid. In that same edge: latch adc_I/Q into cordic_I/Q, set slot=0, copy all shadow freq into active freq.
//   ISSUE: each cycle, cordic_issue=1, cordic_phase=phase[slot]; phase[slot] <= phase[slot]+active_freq[slot] (mod 2^WF, wraps silently).
//   slot increments each ISSUE cycle. After the slot=NRX-1 cycle, return to IDLE.
//  Timing: cordic_issue/cordic_phase/cordic_I/Q are registered; ISSUE occupies NRX consecutive cycles, starting the cycle after adc_valid.
//  busy == (state==ISSUE).
//  adc_valid while busy: sample is dropped and overrun is set; the current batch is unaffected.
//   Required ADC spacing is >= NRX+1 cycles.
//  adc_valid on the exit cycle (slot=NRX-1) is also dropped. It is accepted only in IDLE.
//  overrun_clr and a new overrun in the same cycle: overrun stays 1.
//  Frequency writes:
//   Every freq_wr_en writes shadow[freq_wr_idx], with freq_wr_ack the next cycle.
//   A freq_wr_idx >= NRX is ignored, but is still acked.
//   Shadow values reach the active registers only at batch start, so a batch never mixes old and new words.
//   A write in the same cycle as the accepting adc_valid is NOT included; it applies from the following batch.
//   Two writes to the same index: the last one wins.
//  Phase: the first issue after reset for any receiver is phase 0. The k-th issue of receiver r is sum of its first k-1 active freqs.
//  Tag pipe: CORDIC_LAT-deep shift register of {issue, slot}.
//   When the tag at depth CORDIC_LAT is valid, register cordic_res_I/Q into out_I/Q and set out_valid=1 with out_idx=tag slot,
//   i.e. out_valid is high CORDIC_LAT+1 cycles after the matching cordic_issue.
//   Otherwise out_valid=0 and out_I/Q hold their values.
//  Ordering: results for one sample emerge in idx order 0..NRX-1 on consecutive cycles.
//  Reset mid-batch: the batch is abandoned and the tag pipe is cleared, so no out_valid occurs until a new post-reset issue has traversed the pipe.
// TESTING
//  T1 Reset, then set freq[0]=0x40000000 and the others 0, followed by 4 adc_valid (I=1000, Q=0) at spacing 8.
//     -> receiver-0 cordic_phase sequence 0, 0x40000000, 0x80000000, 0xC0000000; the other receivers stay at phase 0.
//  T2 One adc_valid with NRX=4.
//     -> cordic_issue high for exactly 4 cycles, starting 1 cycle after adc_valid, with slots 0,1,2,3.
//     -> out_valid high 4 consecutive cycles with out_idx 0..3, first at issue+21.
//  T3 Two adc_valid strobes 2 cycles apart.
//     -> second strobe dropped, overrun=1 and held; exactly 4 issues. After overrun_clr, overrun=0.
//  T4 Write freq[2]=5 coincident with adc_valid, then send a second sample.
//     -> batch 1 uses old freq (phase[2] unchanged); batch 2 increments phase[2] by 5. freq_wr_ack seen once per write.
//  T5 Set freq[1]=0x7FFFFFFF and run 3 samples.
//     -> phase[1] = 0, 0x7FFFFFFF, 0xFFFFFFFE (wrap, no saturation).
//  T6 Assert rst_n low at slot 2 of a batch.
//     -> all outputs 0 immediately, no out_valid for CORDIC_LAT+1 cycles after release, and the next batch starts at phase 0.

Source files
------------

// File: rtl/cordic_rx_scheduler.sv
// -----------------------------------------------------------------------------
// cordic_rx_scheduler
//
// Shares one fully pipelined, phase-input CORDIC mixer between NRX receivers.
// Each accepted ADC sample is issued NRX times on consecutive cycles, one
// issue per receiver, and each issue carries that receiver's NCO phase. A
// receiver's phase advances by its own frequency word on every issue. A tag
// pipe as deep as the CORDIC latency follows each issue, so every CORDIC
// result comes out labelled with the receiver that owns it.
//
// Ports
//   clock, rst_n                 clock (rising edge), async active-low reset
//   adc_valid, adc_I, adc_Q      new-sample strobe and signed sample
//   freq_wr_en/idx/data          host write into a receiver's shadow freq word
//   freq_wr_ack                  one-cycle pulse, the cycle after any write
//   overrun_clr                  clears the sticky overrun flag
//   cordic_issue/I/Q/phase       registered CORDIC input bundle
//   cordic_res_I/Q               CORDIC result, CORDIC_LAT cycles after issue
//   out_valid/idx/I/Q            registered, tagged result
//   busy                         high while a batch is being issued
//   overrun                      sticky: a sample arrived while busy
//   state_dbg                    current FSM state
//
// Handshake: there is no backpressure on any interface. adc_valid is a
// one-cycle strobe. It is accepted only when the FSM is IDLE. A strobe in any
// other cycle, including the last issue cycle, is dropped and sets overrun.
// cordic_issue and out_valid are qualifiers only. Data on those buses is
// meaningful only in cycles where the qualifier is high.
// -----------------------------------------------------------------------------
module cordic_rx_scheduler #(
  parameter int NRX        = 4,
  parameter int WIDX       = 2,
  parameter int IN_WIDTH   = 16,
  parameter int WF         = 32,
  parameter int WO         = 16,
  parameter int CORDIC_LAT = 20
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                adc_valid,
  input  logic [IN_WIDTH-1:0] adc_I,
  input  logic [IN_WIDTH-1:0] adc_Q,
  input  logic                freq_wr_en,
  input  logic [WIDX-1:0]     freq_wr_idx,
  input  logic [WF-1:0]       freq_wr_data,
  output logic                freq_wr_ack,
  input  logic                overrun_clr,
  output logic                cordic_issue,
  output logic [IN_WIDTH-1:0] cordic_I,
  output logic [IN_WIDTH-1:0] cordic_Q,
  output logic [WF-1:0]       cordic_phase,
  input  logic [WO-1:0]       cordic_res_I,
  input  logic [WO-1:0]       cordic_res_Q,
  output logic                out_valid,
  output logic [WIDX-1:0]     out_idx,
  output logic [WO-1:0]       out_I,
  output logic [WO-1:0]       out_Q,
  output logic                busy,
  output logic                overrun,
  output logic [0:0]          state_dbg
);

  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_ISSUE  = 1'b1;
  localparam logic [WIDX-1:0] LAST_SLOT = WIDX'(NRX - 1);

  logic [0:0]      state;
  // slot is the receiver whose issue is currently on the cordic_* outputs.
  logic [WIDX-1:0] slot;

  logic [WF-1:0] phase_q  [NRX];
  logic [WF-1:0] active_q [NRX];
  logic [WF-1:0] shadow_q [NRX];

  logic          tag_v [CORDIC_LAT];
  logic [WIDX-1:0] tag_s [CORDIC_LAT];

  logic            accept;
  logic            last_slot;
  logic            load;
  logic [WIDX-1:0] next_slot;
  logic [WF-1:0]   next_phase;

  // load is high when the next cycle carries an issue. The issue for
  // next_slot is staged into the output registers at this edge.
  always_comb begin
    accept     = adc_valid && (state == ST_IDLE);
    last_slot  = (state == ST_ISSUE) && (slot == LAST_SLOT);
    load       = accept || ((state == ST_ISSUE) && !last_slot);
    next_slot  = accept ? '0 : slot + WIDX'(1);
    next_phase = '0;
    for (int r = 0; r < NRX; r++) begin
      if (next_slot == WIDX'(r)) next_phase = phase_q[r];
    end
  end

  assign busy      = (state == ST_ISSUE);
  assign state_dbg = state;

  // FSM, issue bundle, and status flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      slot         <= '0;
      cordic_issue <= 1'b0;
      cordic_phase <= '0;
      cordic_I     <= '0;
      cordic_Q     <= '0;
      overrun      <= 1'b0;
      freq_wr_ack  <= 1'b0;
    end else begin
      freq_wr_ack  <= freq_wr_en;
      // A new drop takes priority over a clear in the same cycle.
      overrun      <= (adc_valid && !accept) || (overrun && !overrun_clr);
      cordic_issue <= load;
      if (accept) begin
        state    <= ST_ISSUE;
        cordic_I <= adc_I;
        cordic_Q <= adc_Q;
      end else if (last_slot) begin
        state <= ST_IDLE;
      end
      if (load) begin
        slot         <= next_slot;
        cordic_phase <= next_phase;
      end
    end
  end

  // Frequency words and phase accumulators.
  // The shadow words are copied into the active words when a batch starts.
  // A write in the accepting cycle therefore misses that batch. At that edge
  // the receiver-0 accumulator adds the shadow word directly, because that
  // word is the active value for the batch being started.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NRX; r++) begin
        phase_q[r]  <= '0;
        active_q[r] <= '0;
        shadow_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NRX; r++) begin
        // An index >= NRX matches no receiver, so the write is dropped.
        if (freq_wr_en && (freq_wr_idx == WIDX'(r))) shadow_q[r] <= freq_wr_data;
        if (accept) active_q[r] <= shadow_q[r];
        if (load && (next_slot == WIDX'(r)))
          phase_q[r] <= phase_q[r] + (accept ? shadow_q[r] : active_q[r]);
      end
    end
  end

  // Tag pipe. It follows the issue bundle, so the tag in the last stage lines
  // up with the CORDIC result for that issue.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CORDIC_LAT; k++) begin
        tag_v[k] <= 1'b0;
        tag_s[k] <= '0;
      end
    end else begin
      tag_v[0] <= cordic_issue;
      tag_s[0] <= slot;
      for (int k = 1; k < CORDIC_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_s[k] <= tag_s[k-1];
      end
    end
  end

  // Result register. The data holds its value between valid cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_I     <= '0;
      out_Q     <= '0;
    end else begin
      out_valid <= tag_v[CORDIC_LAT-1];
      if (tag_v[CORDIC_LAT-1]) begin
        out_idx <= tag_s[CORDIC_LAT-1];
        out_I   <= cordic_res_I;
        out_Q   <= cordic_res_Q;
      end
    end
  end

endmodule
